mdpc_syndrome_encoder: RTL and testbench

Transmit-side counterpart of the QC-MDPC bit-flipping decoder. Samples a sparse error pair (e0, e1) of exact total weight T from an external random-position stream, then computes the syndrome s = e0·h0 + e1·h1 over GF(2)[x]/(x^R−1) from the sparse h0/h1 position lists. Sits between the KEM's randomness source and the ciphertext path. Its s output, for the same h positions, is the syndrome the decoder must reduce to zero.

---
 rtl/mdpc_syndrome_encoder_if.sv | 30 +++
 rtl/mdpc_syndrome_encoder.sv | 156 +++++++++++++++
 tb/tb_mdpc_syndrome_encoder.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdpc_syndrome_encoder_if.sv
// Handshake and data bundle for the QC-MDPC syndrome encoder.
// The slave side is the encoder. The master side is its driver (KEM control / randomness source).
interface mdpc_syndrome_encoder_if #(
  parameter int unsigned R     = 127,
  parameter int unsigned W     = 5,
  parameter int unsigned POS_W = 8,
  parameter int unsigned T     = 4
);
  logic                 i_start;
  logic [W*POS_W-1:0]   i_h0_pos_flat;
  logic [W*POS_W-1:0]   i_h1_pos_flat;
  logic                 i_rnd_valid;
  logic [POS_W:0]       i_rnd_data;
  logic                 o_rnd_ready;
  logic [R-1:0]         o_e0;
  logic [R-1:0]         o_e1;
  logic [R-1:0]         o_s;
  logic                 o_busy;
  logic                 o_done;

  modport master (
    output i_start, i_h0_pos_flat, i_h1_pos_flat, i_rnd_valid, i_rnd_data,
    input  o_rnd_ready, o_e0, o_e1, o_s, o_busy, o_done
  );

  modport slave (
    input  i_start, i_h0_pos_flat, i_h1_pos_flat, i_rnd_valid, i_rnd_data,
    output o_rnd_ready, o_e0, o_e1, o_s, o_busy, o_done
  );
endinterface

// File: rtl/mdpc_syndrome_encoder.sv
// QC-MDPC syndrome encoder: samples a weight-T sparse error pair (e0, e1)
// from a random position stream, then accumulates s = e0*h0 + e1*h1 mod (x^R - 1).
// It performs one sparse toggle per cycle, so ACCUM takes T*W cycles.
module mdpc_syndrome_encoder #(
  parameter int unsigned R     = 127,
  parameter int unsigned W     = 5,
  parameter int unsigned POS_W = 8,
  parameter int unsigned T     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  mdpc_syndrome_encoder_if.slave    if_bus
);

  localparam int unsigned IDX_W = POS_W + 1;
  localparam int unsigned CNT_W = $clog2(T + 1);
  localparam int unsigned J_W   = (T > 1) ? $clog2(T) : 1;
  localparam int unsigned K_W   = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SAMPLE = 2'd1;
  localparam logic [1:0] S_ACCUM  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       r_state;
  logic [R-1:0]     r_e0;
  logic [R-1:0]     r_e1;
  logic [R-1:0]     r_s;
  logic [CNT_W-1:0] r_cnt;
  logic [J_W-1:0]   r_j;
  logic [K_W-1:0]   r_k;
  logic [POS_W:0]   r_list [T];

  logic             w_sel;
  logic [POS_W-1:0] w_pos;
  logic             w_handshake;
  logic             w_in_range;
  logic [R-1:0]     w_pos_mask;
  logic             w_dup;
  logic             w_accept;
  logic             w_last_accept;
  logic [POS_W:0]   w_ent;
  logic [POS_W-1:0] w_hpos;
  logic [IDX_W-1:0] w_sum;
  logic [IDX_W-1:0] w_idx;
  logic [R-1:0]     w_toggle;
  logic             w_k_last;
  logic             w_j_last;

  assign w_sel         = if_bus.i_rnd_data[POS_W];
  assign w_pos         = if_bus.i_rnd_data[POS_W-1:0];
  assign w_handshake   = if_bus.i_rnd_valid && (r_state == S_SAMPLE);
  assign w_in_range    = (w_pos < POS_W'(R));
  assign w_dup         = |((w_sel ? r_e1 : r_e0) & w_pos_mask);
  assign w_accept      = w_handshake && w_in_range && !w_dup;
  assign w_last_accept = w_accept && (r_cnt == CNT_W'(T - 1));
  assign w_k_last      = (r_k == K_W'(W - 1));
  assign w_j_last      = (r_j == J_W'(T - 1));

  // Select the current error entry and the h position it is paired with.
  always_comb begin
    w_ent  = '0;
    w_hpos = '0;
    for (int unsigned j = 0; j < T; j++) begin
      if (r_j == J_W'(j)) w_ent = r_list[j];
    end
    for (int unsigned k = 0; k < W; k++) begin
      if (r_k == K_W'(k)) begin
        w_hpos = w_ent[POS_W] ? if_bus.i_h1_pos_flat[k*POS_W +: POS_W]
                              : if_bus.i_h0_pos_flat[k*POS_W +: POS_W];
      end
    end
  end

  // Cyclic index of the syndrome bit hit by this (entry, h position) pair.
  // Both operands are < R, so a single conditional subtract is enough.
  always_comb begin
    w_sum = {1'b0, w_ent[POS_W-1:0]} + {1'b0, w_hpos};
    w_idx = (w_sum >= IDX_W'(R)) ? (w_sum - IDX_W'(R)) : w_sum;
  end

  // One-hot decodes of the candidate position and the toggle index.
  // Out-of-range values decode to an all-zero mask.
  always_comb begin
    w_pos_mask = '0;
    w_toggle   = '0;
    for (int unsigned b = 0; b < R; b++) begin
      w_pos_mask[b] = (w_pos == POS_W'(b));
      w_toggle[b]   = (w_idx == IDX_W'(b));
    end
  end

  // Control FSM together with the sampled vectors, the accept list and the syndrome.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_e0    <= '0;
      r_e1    <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
      r_j     <= '0;
      r_k     <= '0;
      for (int unsigned e = 0; e < T; e++) r_list[e] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (if_bus.i_start) begin
            r_e0    <= '0;
            r_e1    <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (w_accept) begin
            if (w_sel) r_e1 <= r_e1 | w_pos_mask;
            else       r_e0 <= r_e0 | w_pos_mask;
            for (int unsigned e = 0; e < T; e++) begin
              if (r_cnt == CNT_W'(e)) r_list[e] <= {w_sel, w_pos};
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last_accept) begin
              r_j     <= '0;
              r_k     <= '0;
              r_state <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          r_s <= r_s ^ w_toggle;
          if (w_k_last) begin
            r_k <= '0;
            if (w_j_last) r_state <= S_DONE;
            else          r_j     <= r_j + J_W'(1);
          end else begin
            r_k <= r_k + K_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign if_bus.o_rnd_ready = (r_state == S_SAMPLE);
  assign if_bus.o_busy      = (r_state == S_SAMPLE) || (r_state == S_ACCUM);
  assign if_bus.o_done      = (r_state == S_DONE);
  assign if_bus.o_e0        = r_e0;
  assign if_bus.o_e1        = r_e1;
  assign if_bus.o_s         = r_s;

endmodule

// File: tb/tb_mdpc_syndrome_encoder.sv
// Directed bench for mdpc_syndrome_encoder with hand-computed expected vectors.
module tb_mdpc_syndrome_encoder;

  localparam int R     = 127;
  localparam int W     = 5;
  localparam int POS_W = 8;
  localparam int T     = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdpc_syndrome_encoder_if #(.R(R), .W(W), .POS_W(POS_W), .T(T)) bus ();

  mdpc_syndrome_encoder #(.R(R), .W(W), .POS_W(POS_W), .T(T)) dut (
    .clk    (clk),
    .rst    (rst),
    .if_bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [POS_W:0] seq_d [32];
  bit             seq_v [32];
  int             h0a [5];
  int             h1a [5];

  task automatic apply_h();
    for (int k = 0; k < W; k++) begin
      bus.i_h0_pos_flat[k*POS_W +: POS_W] = POS_W'(h0a[k]);
      bus.i_h1_pos_flat[k*POS_W +: POS_W] = POS_W'(h1a[k]);
    end
  endtask

  task automatic put(input int i, input bit v, input bit sel, input int pos);
    seq_v[i] = v;
    seq_d[i] = {sel, POS_W'(pos)};
  endtask

  // Start a run and feed n table entries, one per SAMPLE cycle.
  // It returns the cycle (counted from the start edge) in which done was seen.
  task automatic run_seq(input int n, input bit hold_start, input int abort_cyc,
                         output int done_cyc, output bit ready_ok, output logic busy_at_done);
    int i;
    done_cyc     = -1;
    ready_ok     = 1'b1;
    busy_at_done = 1'bx;
    i            = 0;
    @(negedge clk);
    bus.i_start     = 1'b1;
    bus.i_rnd_valid = 1'b0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      bus.i_start = hold_start;
      if (cyc == abort_cyc) return;
      if (bus.o_done === 1'b1) begin
        done_cyc     = cyc;
        busy_at_done = bus.o_busy;
        break;
      end
      if (i < n) begin
        if (bus.o_rnd_ready !== 1'b1) ready_ok = 1'b0;
        bus.i_rnd_valid = seq_v[i];
        bus.i_rnd_data  = seq_d[i];
        i++;
      end else begin
        bus.i_rnd_valid = 1'b0;
      end
      @(posedge clk);
    end
    bus.i_rnd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_rnd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b ready=%b expected 000", bus.o_busy, bus.o_done, bus.o_rnd_ready);
    end
    checks++;
    if (bus.o_e0 !== '0 || bus.o_e1 !== '0 || bus.o_s !== '0) begin
      errors++;
      $display("FAIL reset_vec: e0=%h e1=%h s=%h expected all zero", bus.o_e0, bus.o_e1, bus.o_s);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_wrap_seq();
    h0a = '{0, 1, 2, 3, 4};
    h1a = '{0, 1, 2, 3, 4};
    apply_h();
    put(0, 1'b1, 1'b0, 0);
    put(1, 1'b1, 1'b0, 1);
    put(2, 1'b1, 1'b1, 126);
    put(3, 1'b1, 1'b1, 125);
  endtask

  task automatic check_wrap_result(input string tag, input int done_cyc, input int exp_cyc);
    logic [R-1:0] exp_e0, exp_e1, exp_s;
    int sb [4] = '{0, 3, 5, 125};
    exp_e0 = '0; exp_e0[0] = 1'b1; exp_e0[1] = 1'b1;
    exp_e1 = '0; exp_e1[125] = 1'b1; exp_e1[126] = 1'b1;
    exp_s  = '0;
    foreach (sb[i]) exp_s[sb[i]] = 1'b1;
    checks++;
    if (done_cyc != exp_cyc) begin
      errors++;
      $display("FAIL %s_done_cycle: got %0d expected %0d", tag, done_cyc, exp_cyc);
    end
    checks++;
    if (bus.o_e0 !== exp_e0 || bus.o_e1 !== exp_e1) begin
      errors++;
      $display("FAIL %s_e: e0=%h e1=%h expected e0=%h e1=%h", tag, bus.o_e0, bus.o_e1, exp_e0, exp_e1);
    end
    checks++;
    if (bus.o_s !== exp_s) begin
      errors++;
      $display("FAIL %s_s: got %h expected %h", tag, bus.o_s, exp_s);
    end
  endtask

  task automatic test_wrap_cancel();
    int dc; bit rok; logic bd;
    load_wrap_seq();
    run_seq(4, 1'b0, 0, dc, rok, bd);
    check_wrap_result("wrap", dc, 25);
    checks++;
    if (bd !== 1'b0 || rok !== 1'b1) begin
      errors++;
      $display("FAIL wrap_busy_ready: busy_at_done=%b ready_ok=%b expected 0 1", bd, rok);
    end
    @(negedge clk);
  endtask

  task automatic test_rejection();
    int dc; bit rok; logic bd;
    logic [R-1:0] exp_e0, exp_e1, exp_s;
    int sb [10] = '{0, 1, 2, 3, 4, 100, 101, 102, 103, 104};
    h0a = '{0, 1, 2, 3, 4};
    h1a = '{0, 1, 2, 3, 4};
    apply_h();
    put(0, 1'b1, 1'b0, 0);
    put(1, 1'b1, 1'b0, 127);
    put(2, 1'b1, 1'b0, 7);
    put(3, 1'b1, 1'b1, 255);
    put(4, 1'b1, 1'b0, 7);
    put(5, 1'b1, 1'b1, 7);
    put(6, 1'b1, 1'b1, 100);
    run_seq(7, 1'b0, 0, dc, rok, bd);
    exp_e0 = '0; exp_e0[0] = 1'b1; exp_e0[7] = 1'b1;
    exp_e1 = '0; exp_e1[7] = 1'b1; exp_e1[100] = 1'b1;
    exp_s  = '0;
    foreach (sb[i]) exp_s[sb[i]] = 1'b1;
    checks++;
    if (dc != 28) begin
      errors++;
      $display("FAIL reject_done_cycle: got %0d expected 28", dc);
    end
    checks++;
    if (rok !== 1'b1) begin
      errors++;
      $display("FAIL reject_ready: ready dropped during rejects, got %b expected 1", rok);
    end
    checks++;
    if (bus.o_e0 !== exp_e0 || bus.o_e1 !== exp_e1) begin
      errors++;
      $display("FAIL reject_e: e0=%h e1=%h expected e0=%h e1=%h", bus.o_e0, bus.o_e1, exp_e0, exp_e1);
    end
    checks++;
    if (bus.o_s !== exp_s) begin
      errors++;
      $display("FAIL reject_s: got %h expected %h", bus.o_s, exp_s);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int dc; bit rok; logic bd;
    load_wrap_seq();
    put(0, 1'b1, 1'b0, 0);
    put(1, 1'b1, 1'b0, 1);
    put(2, 1'b0, 1'b0, 50);
    put(3, 1'b0, 1'b1, 60);
    put(4, 1'b0, 1'b0, 70);
    put(5, 1'b1, 1'b1, 126);
    put(6, 1'b1, 1'b1, 125);
    run_seq(7, 1'b0, 0, dc, rok, bd);
    check_wrap_result("gap", dc, 28);
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int dc; bit rok; logic bd;
    logic [R-1:0] s_hold, e0_hold, e1_hold;
    bit stable, quiet;
    load_wrap_seq();
    run_seq(4, 1'b1, 0, dc, rok, bd);
    check_wrap_result("hold", dc, 25);
    @(negedge clk);
    bus.i_start = 1'b0;
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_no_restart: busy=%b expected 0", bus.o_busy);
    end
    s_hold = bus.o_s; e0_hold = bus.o_e0; e1_hold = bus.o_e1;
    stable = 1'b1; quiet = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.o_s !== s_hold || bus.o_e0 !== e0_hold || bus.o_e1 !== e1_hold) stable = 1'b0;
      if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!stable || !quiet) begin
      errors++;
      $display("FAIL idle_hold: stable=%b quiet=%b expected 1 1", stable, quiet);
    end
  endtask

  task automatic test_loopback();
    int dc; bit rok; logic bd;
    logic [R-1:0] exp_e0, exp_e1, exp_s;
    int sb [20] = '{9, 13, 60, 87, 110, 43, 70, 93, 119, 123,
                    8, 11, 30, 74, 100, 23, 58, 61, 80, 124};
    h0a = '{3, 50, 77, 100, 126};
    h1a = '{1, 20, 64, 90, 125};
    apply_h();
    put(0, 1'b1, 1'b0, 10);
    put(1, 1'b1, 1'b1, 10);
    put(2, 1'b1, 1'b0, 120);
    put(3, 1'b1, 1'b1, 60);
    run_seq(4, 1'b0, 0, dc, rok, bd);
    exp_e0 = '0; exp_e0[10] = 1'b1; exp_e0[120] = 1'b1;
    exp_e1 = '0; exp_e1[10] = 1'b1; exp_e1[60] = 1'b1;
    exp_s  = '0;
    foreach (sb[i]) exp_s[sb[i]] = 1'b1;
    checks++;
    if (dc != 25) begin
      errors++;
      $display("FAIL loop_done_cycle: got %0d expected 25", dc);
    end
    checks++;
    if ($countones(bus.o_e0) + $countones(bus.o_e1) != T) begin
      errors++;
      $display("FAIL loop_weight: got %0d expected %0d", $countones(bus.o_e0) + $countones(bus.o_e1), T);
    end
    checks++;
    if (bus.o_e0 !== exp_e0 || bus.o_e1 !== exp_e1) begin
      errors++;
      $display("FAIL loop_e: e0=%h e1=%h expected e0=%h e1=%h", bus.o_e0, bus.o_e1, exp_e0, exp_e1);
    end
    checks++;
    if (bus.o_s !== exp_s) begin
      errors++;
      $display("FAIL loop_s: got %h expected %h", bus.o_s, exp_s);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_accum();
    int dc; bit rok; logic bd;
    load_wrap_seq();
    run_seq(4, 1'b0, 10, dc, rok, bd);
    checks++;
    if (bus.o_busy !== 1'b1 || bus.o_e0 === '0) begin
      errors++;
      $display("FAIL pre_reset_busy: busy=%b e0=%h expected busy 1 and e0 nonzero", bus.o_busy, bus.o_e0);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_rnd_ready !== 1'b0 ||
        bus.o_e0 !== '0 || bus.o_e1 !== '0 || bus.o_s !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b ready=%b e0=%h e1=%h s=%h expected all zero",
               bus.o_busy, bus.o_done, bus.o_rnd_ready, bus.o_e0, bus.o_e1, bus.o_s);
    end
    @(negedge clk);
    rst = 1'b0;
    run_seq(4, 1'b0, 0, dc, rok, bd);
    check_wrap_result("post_reset", dc, 25);
    @(negedge clk);
  endtask

  initial begin
    rst                = 1'b1;
    bus.i_start        = 1'b0;
    bus.i_rnd_valid    = 1'b0;
    bus.i_rnd_data     = '0;
    bus.i_h0_pos_flat  = '0;
    bus.i_h1_pos_flat  = '0;
    test_reset();
    test_wrap_cancel();
    test_rejection();
    test_backpressure();
    test_start_ignored();
    test_loopback();
    test_reset_mid_accum();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
